// File: rtl/frame_draw_scheduler.sv
// -----------------------------------------------------------------------------
// frame_draw_scheduler
//
// Per-frame sequencer that drives the object-position select and the box
// drawer. On every frame tick it erases each object at its old position,
// pulses a position update, waits for the position and collision registers to
// settle, redraws each object at its new position and finally samples the
// collision flag. A collision parks the sequencer in HALT until reset.
//
// Ports
//   Clock            system clock
//   Reset            synchronous, active-low reset
//   frameTick        one-cycle frame start pulse
//   collisionOccured registered collision flag from the position block
//   objX / objY      position of the currently selected object (combinational
//                    from 'object')
//   drawDone         one-cycle pulse from the drawer: box finished
//   object           object select index (0 when not sequencing)
//   drawStart        one-cycle pulse: drawer starts on the latched box
//   boxX/boxY        box origin
//   boxW/boxH        box size
//   colour           box colour
//   updateEn         one-cycle pulse: positions advance one step
//   busy             high in every state except IDLE and HALT
//   gameOver         sticky collision indication
// -----------------------------------------------------------------------------
module frame_draw_scheduler #(
  parameter int unsigned NUM_OBJECTS   = 9,
  parameter logic [3:0]  ROCKET_W      = 4'd7,
  parameter logic [3:0]  ROCKET_H      = 4'd15,
  parameter logic [3:0]  AST_W         = 4'd4,
  parameter logic [3:0]  AST_H         = 4'd4,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter logic [2:0]  ROCKET_COLOUR = 3'b111,
  parameter logic [2:0]  AST_COLOUR    = 3'b110
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       frameTick,
  input  logic       collisionOccured,
  input  logic [7:0] objX,
  input  logic [6:0] objY,
  input  logic       drawDone,
  output logic [7:0] object,
  output logic       drawStart,
  output logic [7:0] boxX,
  output logic [6:0] boxY,
  output logic [3:0] boxW,
  output logic [3:0] boxH,
  output logic [2:0] colour,
  output logic       updateEn,
  output logic       busy,
  output logic       gameOver
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_OBJECTS);

  typedef enum logic [3:0] {
    IDLE,
    ERASE_SEL,
    ERASE_WAIT,
    UPDATE,
    SETTLE1,
    SETTLE2,
    DRAW_SEL,
    DRAW_WAIT,
    CHECK,
    HALT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic        game_over_q, game_over_d;
  logic [7:0]  object_q, object_d;
  logic        draw_start_q, draw_start_d;
  logic        update_en_q, update_en_d;
  logic        busy_q, busy_d;
  logic [7:0]  box_x_q, box_x_d;
  logic [6:0]  box_y_q, box_y_d;
  logic [3:0]  box_w_q, box_w_d;
  logic [3:0]  box_h_q, box_h_d;
  logic [2:0]  colour_q, colour_d;

  logic        is_rocket;
  logic        busy_state;
  logic        next_selects;

  assign is_rocket = (idx_q == 4'd1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pending_d   = pending_q;
    game_over_d = game_over_q;
    box_x_d     = box_x_q;
    box_y_d     = box_y_q;
    box_w_d     = box_w_q;
    box_h_d     = box_h_q;
    colour_d    = colour_q;

    case (state_q)
      IDLE: begin
        if (frameTick || pending_q) begin
          pending_d = 1'b0;
          idx_d     = 4'd1;
          state_d   = ERASE_SEL;
        end
      end

      // The object select has been showing idx for this whole cycle, so
      // objX/objY are valid here and are captured into the box registers.
      ERASE_SEL, DRAW_SEL: begin
        box_x_d = objX;
        box_y_d = objY;
        box_w_d = is_rocket ? ROCKET_W : AST_W;
        box_h_d = is_rocket ? ROCKET_H : AST_H;
        if (state_q == ERASE_SEL) begin
          colour_d = BG_COLOUR;
          state_d  = ERASE_WAIT;
        end else begin
          colour_d = is_rocket ? ROCKET_COLOUR : AST_COLOUR;
          state_d  = DRAW_WAIT;
        end
      end

      ERASE_WAIT: begin
        if (drawDone) begin
          if (idx_q == LAST_IDX) begin
            state_d = UPDATE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = ERASE_SEL;
          end
        end
      end

      UPDATE: begin
        idx_d   = 4'd1;
        state_d = SETTLE1;
      end

      // Two idle cycles: positions register first, then the collision flag.
      SETTLE1: state_d = SETTLE2;
      SETTLE2: state_d = DRAW_SEL;

      DRAW_WAIT: begin
        if (drawDone) begin
          if (idx_q == LAST_IDX) begin
            state_d = CHECK;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = DRAW_SEL;
          end
        end
      end

      CHECK: begin
        if (collisionOccured) begin
          game_over_d = 1'b1;
          state_d     = HALT;
        end else begin
          state_d = IDLE;
        end
      end

      HALT: state_d = HALT;

      default: state_d = IDLE;
    endcase

    // A tick arriving while a frame is in flight is remembered once; further
    // ticks collapse into the same pending frame. HALT never queues work.
    busy_state = (state_q != IDLE) && (state_q != HALT);
    if (frameTick && busy_state) begin
      pending_d = 1'b1;
    end

    // Outputs are decoded from the next state so that, once registered, they
    // line up cycle-for-cycle with the state they belong to.
    next_selects = (state_d == ERASE_SEL) || (state_d == ERASE_WAIT) ||
                   (state_d == DRAW_SEL)  || (state_d == DRAW_WAIT);
    object_d     = next_selects ? {4'd0, idx_d} : 8'd0;
    draw_start_d = (state_d == ERASE_SEL) || (state_d == DRAW_SEL);
    update_en_d  = (state_d == UPDATE);
    busy_d       = (state_d != IDLE) && (state_d != HALT);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= IDLE;
      idx_q        <= 4'd1;
      pending_q    <= 1'b0;
      game_over_q  <= 1'b0;
      object_q     <= 8'd0;
      draw_start_q <= 1'b0;
      update_en_q  <= 1'b0;
      busy_q       <= 1'b0;
      box_x_q      <= 8'd0;
      box_y_q      <= 7'd0;
      box_w_q      <= 4'd0;
      box_h_q      <= 4'd0;
      colour_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      game_over_q  <= game_over_d;
      object_q     <= object_d;
      draw_start_q <= draw_start_d;
      update_en_q  <= update_en_d;
      busy_q       <= busy_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      box_w_q      <= box_w_d;
      box_h_q      <= box_h_d;
      colour_q     <= colour_d;
    end
  end

  assign object    = object_q;
  assign drawStart = draw_start_q;
  assign updateEn  = update_en_q;
  assign busy      = busy_q;
  assign gameOver  = game_over_q;
  assign boxX      = box_x_q;
  assign boxY      = box_y_q;
  assign boxW      = box_w_q;
  assign boxH      = box_h_q;
  assign colour    = colour_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_draw_scheduler
//
// Scoreboard bench. Each frame the bench expects to run is expanded into the
// ordered list of transactions it must produce (nine erases, one update, nine
// draws) and queued. A monitor pops the queue on every drawStart / updateEn.
// A position-block model supplies objX/objY and the collision flag, and a
// drawer model answers each drawStart with drawDone k cycles later.
// -----------------------------------------------------------------------------
module tb_frame_draw_scheduler;

  localparam int NOBJ = 9;

  logic       Clock;
  logic       Reset;
  logic       frameTick;
  logic       collisionOccured;
  logic [7:0] objX;
  logic [6:0] objY;
  logic       drawDone;
  logic [7:0] object;
  logic       drawStart;
  logic [7:0] boxX;
  logic [6:0] boxY;
  logic [3:0] boxW;
  logic [3:0] boxH;
  logic [2:0] colour;
  logic       updateEn;
  logic       busy;
  logic       gameOver;

  frame_draw_scheduler dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .frameTick        (frameTick),
    .collisionOccured (collisionOccured),
    .objX             (objX),
    .objY             (objY),
    .drawDone         (drawDone),
    .object           (object),
    .drawStart        (drawStart),
    .boxX             (boxX),
    .boxY             (boxY),
    .boxW             (boxW),
    .boxH             (boxH),
    .colour           (colour),
    .updateEn         (updateEn),
    .busy             (busy),
    .gameOver         (gameOver)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------------------------------------------------------- counters
  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_upd = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // ---------------------------------------------------------- reference model
  typedef struct {
    bit is_upd;
    int obj;
    int x;
    int y;
    int w;
    int h;
    int col;
  } exp_t;

  typedef struct packed {
    logic [15:0][7:0] x;
    logic [15:0][6:0] y;
  } pos_set_t;

  exp_t     exp_q[$];
  pos_set_t pos_q[$];
  int       mx[16];
  int       my[16];

  function automatic int init_x(input int i);
    return (i == 1) ? 20 : (i == 4) ? 100 : i * 13;
  endfunction

  function automatic int init_y(input int i);
    return (i == 1) ? 50 : (i == 4) ? 10 : i * 6;
  endfunction

  // One frame: erase every object where it is, advance positions, draw every
  // object where it now is. Rocket is object 1, everything else an asteroid.
  task automatic push_frame(input bit keep_fixed);
    exp_t     e;
    pos_set_t ps;
    ps = '0;
    for (int i = 1; i <= NOBJ; i++) begin
      e = '{is_upd: 1'b0, obj: i, x: mx[i], y: my[i],
            w: (i == 1) ? 7 : 4, h: (i == 1) ? 15 : 4, col: 0};
      exp_q.push_back(e);
    end
    e = '{is_upd: 1'b1, obj: 0, x: 0, y: 0, w: 0, h: 0, col: 0};
    exp_q.push_back(e);
    for (int i = 1; i <= NOBJ; i++) begin
      if (!(keep_fixed && (i == 1 || i == 4))) begin
        mx[i] = int'($urandom_range(0, 255));
        my[i] = int'($urandom_range(0, 127));
      end
      ps.x[i] = 8'(mx[i]);
      ps.y[i] = 7'(my[i]);
    end
    for (int i = 1; i <= NOBJ; i++) begin
      e = '{is_upd: 1'b0, obj: i, x: mx[i], y: my[i],
            w: (i == 1) ? 7 : 4, h: (i == 1) ? 15 : 4,
            col: (i == 1) ? 7 : 6};
      exp_q.push_back(e);
    end
    pos_q.push_back(ps);
  endtask

  // ------------------------------------------------------ position block model
  logic [7:0] cur_x[16];
  logic [6:0] cur_y[16];
  bit         collide_req;
  int         coll_cnt;

  assign objX = cur_x[object[3:0]];
  assign objY = cur_y[object[3:0]];

  initial begin
    pos_set_t ps;
    for (int i = 0; i < 16; i++) begin
      cur_x[i] = 8'(init_x(i));
      cur_y[i] = 7'(init_y(i));
    end
    collisionOccured = 1'b0;
    coll_cnt = 0;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        collisionOccured = 1'b0;
        coll_cnt = 0;
      end else begin
        // Collision flag is registered behind the position registers, so it
        // becomes valid two cycles after the update pulse.
        if (coll_cnt > 0) begin
          coll_cnt--;
          if (coll_cnt == 0) collisionOccured = collide_req;
        end
        if (updateEn) begin
          if (pos_q.size() > 0) begin
            ps = pos_q.pop_front();
            for (int i = 0; i < 16; i++) begin
              cur_x[i] = ps.x[i];
              cur_y[i] = ps.y[i];
            end
          end
          coll_cnt = 2;
        end
      end
    end
  end

  // ------------------------------------------------------------- drawer model
  int   k_lat;
  bit   abuse;
  logic drv_done;
  logic extra_done;
  int   drv_cnt;

  assign drawDone = drv_done | extra_done;

  initial begin
    drv_done = 1'b0;
    drv_cnt  = 0;
    forever begin
      @(negedge Clock);
      drv_done = 1'b0;
      if (!Reset) begin
        drv_cnt = 0;
      end else begin
        if (drv_cnt > 0) begin
          drv_cnt--;
          if (drv_cnt == 0) drv_done = 1'b1;
        end
        if (drawStart) begin
          drv_cnt = k_lat;
          if (abuse) drv_done = 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------ monitor
  bit   box_pending = 0;
  exp_t box_exp;

  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      // Box registers are captured at the end of the select cycle, so they
      // are checked one cycle after the drawStart pulse.
      if (box_pending) begin
        box_pending = 0;
        check("boxX", 32'(boxX), 32'(box_exp.x));
        check("boxY", 32'(boxY), 32'(box_exp.y));
        check("boxW", 32'(boxW), 32'(box_exp.w));
        check("boxH", 32'(boxH), 32'(box_exp.h));
        check("colour", 32'(colour), 32'(box_exp.col));
      end
      if (Reset && drawStart) begin
        n_start++;
        if (exp_q.size() == 0) begin
          check("unexpected_drawStart", 32'(object), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          $display("draw #%0d object=%0d exp_object=%0d exp_colour=%0d",
                   n_start, object, e.obj, e.col);
          check("seq_kind_at_drawStart", 32'(0), 32'(e.is_upd));
          check("object", 32'(object), 32'(e.obj));
          box_exp = e;
          box_pending = !e.is_upd;
        end
      end
      if (Reset && updateEn) begin
        n_upd++;
        $display("update #%0d", n_upd);
        if (exp_q.size() == 0) begin
          check("unexpected_updateEn", 32'(0), 32'(1));
        end else begin
          e = exp_q.pop_front();
          check("seq_kind_at_updateEn", 32'(1), 32'(e.is_upd));
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    frameTick = 1'b1;
    @(negedge Clock);
    frameTick = 1'b0;
  endtask

  // Wait for busy to rise, then count cycles until it falls.
  task automatic run_wait(output int cyc);
    int t;
    cyc = 0;
    t = 0;
    while (!busy && t < 20) begin
      @(negedge Clock);
      t++;
    end
    if (!busy) begin
      check("frame_started", 32'(0), 32'(1));
      return;
    end
    while (busy && cyc < 5000) begin
      @(negedge Clock);
      cyc++;
    end
    if (busy) check("frame_finished", 32'(0), 32'(1));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0d, expected finish", busy);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int gap;
    int s0;
    int u0;
    bit found;

    Reset       = 1'b0;
    frameTick   = 1'b0;
    extra_done  = 1'b0;
    k_lat       = 3;
    abuse       = 0;
    collide_req = 0;
    for (int i = 0; i < 16; i++) begin
      mx[i] = init_x(i);
      my[i] = init_y(i);
    end

    // Reset state
    repeat (3) @(negedge Clock);
    check("rst_object", 32'(object), 32'(0));
    check("rst_drawStart", 32'(drawStart), 32'(0));
    check("rst_updateEn", 32'(updateEn), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_gameOver", 32'(gameOver), 32'(0));
    check("rst_boxX", 32'(boxX), 32'(0));
    check("rst_boxW", 32'(boxW), 32'(0));
    check("rst_colour", 32'(colour), 32'(0));
    Reset = 1'b1;
    @(negedge Clock);

    // Single frame, k=3, rocket at (20,50), object 4 at (100,10)
    s0 = n_start;
    u0 = n_upd;
    push_frame(1'b1);
    tick();
    run_wait(cyc);
    check("f1_busy_cycles", 32'(cyc), 32'(2 * NOBJ * (1 + 3) + 4));
    check("f1_drawStarts", 32'(n_start - s0), 32'(18));
    check("f1_updates", 32'(n_upd - u0), 32'(1));
    check("f1_queue_drained", 32'(exp_q.size()), 32'(0));
    check("f1_idle_object", 32'(object), 32'(0));
    repeat (3) @(negedge Clock);

    // Random positions, random drawer latency
    for (int f = 0; f < 4; f++) begin
      k_lat = int'($urandom_range(1, 6));
      push_frame(1'b0);
      tick();
      run_wait(cyc);
      check("rnd_busy_cycles", 32'(cyc), 32'(2 * NOBJ * (1 + k_lat) + 4));
      check("rnd_queue_drained", 32'(exp_q.size()), 32'(0));
      repeat (int'($urandom_range(1, 5))) @(negedge Clock);
    end

    // Handshake abuse: done in IDLE and done together with drawStart
    k_lat = 3;
    extra_done = 1'b1;
    @(negedge Clock);
    extra_done = 1'b0;
    @(negedge Clock);
    check("idle_done_busy", 32'(busy), 32'(0));
    check("idle_done_drawStart", 32'(drawStart), 32'(0));
    abuse = 1;
    push_frame(1'b0);
    tick();
    run_wait(cyc);
    abuse = 0;
    check("abuse_busy_cycles", 32'(cyc), 32'(2 * NOBJ * (1 + 3) + 4));
    check("abuse_queue_drained", 32'(exp_q.size()), 32'(0));
    repeat (3) @(negedge Clock);

    // Overrun: several ticks during one frame give exactly one extra frame
    s0 = n_start;
    push_frame(1'b0);
    push_frame(1'b0);
    tick();
    fork
      begin
        repeat (3) begin
          repeat (10) @(negedge Clock);
          tick();
        end
      end
      run_wait(cyc);
    join
    check("ovr_f1_cycles", 32'(cyc), 32'(76));
    gap = 0;
    while (!busy && gap < 50) begin
      @(negedge Clock);
      gap++;
    end
    check("ovr_idle_gap", 32'(gap), 32'(1));
    run_wait(cyc);
    check("ovr_f2_cycles", 32'(cyc), 32'(76));
    check("ovr_drawStarts", 32'(n_start - s0), 32'(36));
    repeat (100) @(negedge Clock);
    check("ovr_no_third_frame", 32'(n_start - s0), 32'(36));
    check("ovr_queue_drained", 32'(exp_q.size()), 32'(0));

    // Collision -> HALT
    collide_req = 1;
    push_frame(1'b0);
    tick();
    run_wait(cyc);
    check("col_busy_cycles", 32'(cyc), 32'(76));
    check("col_gameOver", 32'(gameOver), 32'(1));
    check("col_object", 32'(object), 32'(0));
    check("col_queue_drained", 32'(exp_q.size()), 32'(0));
    s0 = n_start;
    u0 = n_upd;
    repeat (3) begin
      tick();
      repeat (20) @(negedge Clock);
    end
    check("halt_drawStarts", 32'(n_start - s0), 32'(0));
    check("halt_updates", 32'(n_upd - u0), 32'(0));
    check("halt_busy", 32'(busy), 32'(0));
    check("halt_gameOver_sticky", 32'(gameOver), 32'(1));
    Reset = 1'b0;
    collide_req = 0;
    @(negedge Clock);
    check("halt_reset_gameOver", 32'(gameOver), 32'(0));
    Reset = 1'b1;
    @(negedge Clock);

    // Reset during DRAW_WAIT of object 5
    u0 = n_upd;
    push_frame(1'b0);
    tick();
    found = 0;
    for (int t = 0; t < 600 && !found; t++) begin
      @(negedge Clock);
      if (drawStart && object == 8'd5 && n_upd > u0) found = 1;
    end
    check("mid_reset_reached_obj5_draw", 32'(found), 32'(1));
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("mid_reset_object", 32'(object), 32'(0));
    check("mid_reset_busy", 32'(busy), 32'(0));
    check("mid_reset_drawStart", 32'(drawStart), 32'(0));
    check("mid_reset_gameOver", 32'(gameOver), 32'(0));
    exp_q.delete();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    push_frame(1'b0);
    tick();
    check("restart_object", 32'(object), 32'(1));
    check("restart_drawStart", 32'(drawStart), 32'(1));
    run_wait(cyc);
    check("restart_busy_cycles", 32'(cyc), 32'(76));
    check("restart_queue_drained", 32'(exp_q.size()), 32'(0));
    repeat (3) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
